// File: rtl/vga_pkg.sv
// Shared constants and bus types for the VGA raster timing generator.
package vga_pkg;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned FRAME_W = 8;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  localparam int unsigned H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int unsigned TILE_SIZE = 32;

  // Raster qualifiers carried through the delay line (all active-high internally).
  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
    logic line_start;
    logic frame_start;
  } sync_bus_t;

  localparam int unsigned SYNC_W = $bits(sync_bus_t);

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Fixed-depth shift register with async reset to RESET_VALUE; DEPTH=0 is a wire.
module sync_delay_line #(
  parameter int unsigned          WIDTH       = 1,
  parameter int unsigned          DEPTH       = 1,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign q = d;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      // Shift the qualifier vector one stage per clock.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stage <= '{default: RESET_VALUE};
        end else begin
          stage[0] <= d;
          for (int unsigned i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: undelayed h/v counters plus delayed sync/active/strobe outputs.
// Optional frame counter enabled by defining VGA_FRAME_COUNTER_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE       = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT         = DEF_H_FRONT,
  parameter int unsigned H_SYNC          = DEF_H_SYNC,
  parameter int unsigned H_BACK          = DEF_H_BACK,
  parameter int unsigned V_VISIBLE       = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT         = DEF_V_FRONT,
  parameter int unsigned V_SYNC          = DEF_V_SYNC,
  parameter int unsigned V_BACK          = DEF_V_BACK,
  parameter int unsigned SYNC_DELAY      = 1,   // legal 0..4
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  output logic [CNT_W-1:0]   h_count,
  output logic [CNT_W-1:0]   v_count,
  output logic               display_active,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int unsigned H_TOT    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOT    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic             h_wrap;
  logic             v_wrap;
  logic             frame_wrap;
  sync_bus_t        raw;
  sync_bus_t        dly;

  // Next raster position; anything at or past the last position wraps to 0.
  always_comb begin
    h_wrap     = (h_count >= CNT_W'(H_TOT - 1));
    v_wrap     = (v_count >= CNT_W'(V_TOT - 1));
    frame_wrap = h_wrap && v_wrap;
    h_next     = h_wrap ? '0 : h_count + CNT_W'(1);
    v_next     = v_count;
    if (v_count >= CNT_W'(V_TOT)) begin
      v_next = '0;
    end else if (h_wrap) begin
      v_next = v_wrap ? '0 : v_count + CNT_W'(1);
    end
  end

  // Raster position registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else begin
      h_count <= h_next;
      v_count <= v_next;
    end
  end

  // Undelayed qualifiers decoded from the current position.
  always_comb begin
    raw             = '0;
    raw.hs          = (h_count >= CNT_W'(HS_START)) && (h_count < CNT_W'(HS_END));
    raw.vs          = (v_count >= CNT_W'(VS_START)) && (v_count < CNT_W'(VS_END));
    raw.active      = (h_count < CNT_W'(H_VISIBLE)) && (v_count < CNT_W'(V_VISIBLE));
    raw.line_start  = (h_count == '0);
    raw.frame_start = (h_count == '0) && (v_count == '0);
  end

  sync_delay_line #(
    .WIDTH       (SYNC_W),
    .DEPTH       (SYNC_DELAY),
    .RESET_VALUE ('0)
  ) u_sync_delay (
    .clk (clk),
    .rst (reset),
    .d   (raw),
    .q   (dly)
  );

  // Polarity applied after the delay so reset leaves syncs deasserted.
  assign hsync          = SYNC_ACTIVE_LOW ? ~dly.hs : dly.hs;
  assign vsync          = SYNC_ACTIVE_LOW ? ~dly.vs : dly.vs;
  assign display_active = dly.active;
  assign line_start     = dly.line_start;
  assign frame_start    = dly.frame_start;

`ifdef VGA_FRAME_COUNTER_EN
  // Frame counter advancing on the full-raster wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count <= '0;
    end else if (frame_wrap) begin
      frame_count <= frame_count + FRAME_W'(1);
    end
  end
`else
  logic unused_frame_wrap;
  assign unused_frame_wrap = frame_wrap;
  assign frame_count       = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full-timing instances at delays 0/1/3 and a
// shrunken-timing instance (16x10 raster, delay 3, active-high syncs) for frame-level checks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  logic [9:0] d1_h, d1_v, d0_h, d0_v, d3_h, d3_v, sm_h, sm_v;
  logic d1_act, d1_hs, d1_vs, d1_ls, d1_fs;
  logic d0_act, d0_hs, d0_vs, d0_ls, d0_fs;
  logic d3_act, d3_hs, d3_vs, d3_ls, d3_fs;
  logic sm_act, sm_hs, sm_vs, sm_ls, sm_fs;
  logic [7:0] d1_fc, d0_fc, d3_fc, sm_fc;

  vga_timing_gen #(.SYNC_DELAY(1)) u_d1 (
    .clk(clk), .reset(reset), .h_count(d1_h), .v_count(d1_v), .display_active(d1_act),
    .hsync(d1_hs), .vsync(d1_vs), .line_start(d1_ls), .frame_start(d1_fs), .frame_count(d1_fc));

  vga_timing_gen #(.SYNC_DELAY(0)) u_d0 (
    .clk(clk), .reset(reset), .h_count(d0_h), .v_count(d0_v), .display_active(d0_act),
    .hsync(d0_hs), .vsync(d0_vs), .line_start(d0_ls), .frame_start(d0_fs), .frame_count(d0_fc));

  vga_timing_gen #(.SYNC_DELAY(3)) u_d3 (
    .clk(clk), .reset(reset), .h_count(d3_h), .v_count(d3_v), .display_active(d3_act),
    .hsync(d3_hs), .vsync(d3_vs), .line_start(d3_ls), .frame_start(d3_fs), .frame_count(d3_fc));

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_DELAY(3), .SYNC_ACTIVE_LOW(1'b0)
  ) u_sm (
    .clk(clk), .reset(reset), .h_count(sm_h), .v_count(sm_v), .display_active(sm_act),
    .hsync(sm_hs), .vsync(sm_vs), .line_start(sm_ls), .frame_start(sm_fs), .frame_count(sm_fc));

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic act;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
  } sm_exp_t;

  // Expected small-raster outputs k clocks after reset release (16x10 raster, delay 3).
  function automatic sm_exp_t sm_model(input int k);
    sm_exp_t e;
    int pos, pd, hd, vd;
    pos   = k % 160;
    e     = '0;
    e.h   = 10'(pos % 16);
    e.v   = 10'(pos / 16);
    if (k >= 3) begin
      pd    = (k - 3) % 160;
      hd    = pd % 16;
      vd    = pd / 16;
      e.act = (hd < 8) && (vd < 6);
      e.hs  = (hd >= 10) && (hd <= 12);
      e.vs  = (vd >= 7) && (vd <= 8);
      e.ls  = (hd == 0);
      e.fs  = (pd == 0);
    end
    return e;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Assert reset over two edges, release on a falling edge; returns at cycle 0.
  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    int fs_pulses;
    #12;
    n_cmp++;
    if ({d1_h, d1_v, d1_act, d1_hs, d1_vs, d1_ls, d1_fs, d1_fc} !== {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      n_bad++;
      $display("FAIL reset_state_d1: got h=%0d v=%0d act=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, expected 0 0 0 1 1 0 0 0",
               d1_h, d1_v, d1_act, d1_hs, d1_vs, d1_ls, d1_fs, d1_fc);
    end
    n_cmp++;
    if ({sm_hs, sm_vs, sm_act} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_state_sm_polarity: got hs=%b vs=%b act=%b, expected 0 0 0", sm_hs, sm_vs, sm_act);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({d1_h, d1_v, d1_act, d1_fs} !== {10'd0, 10'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL cycle0_d1: got h=%0d v=%0d act=%b fs=%b, expected 0 0 0 0", d1_h, d1_v, d1_act, d1_fs);
    end
    step();
    n_cmp++;
    if ({d1_h, d1_act, d1_fs, d1_ls} !== {10'd1, 1'b1, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL cycle1_d1: got h=%0d act=%b fs=%b ls=%b, expected 1 1 1 1", d1_h, d1_act, d1_fs, d1_ls);
    end
    fs_pulses = 0;
    for (int k = 2; k < 800; k++) begin
      step();
      if (d1_fs) fs_pulses++;
    end
    n_cmp++;
    if (fs_pulses !== 0) begin
      n_bad++;
      $display("FAIL frame_start_single_pulse: got %0d extra pulses, expected 0", fs_pulses);
    end
  endtask

  task automatic test_hsync();
    int lows, first_fall_h, fall0, fall1, n_fall;
    logic prev_hs, exp_hs;
    int hp;
    apply_reset();
    lows = 0; first_fall_h = -1; fall0 = -1; fall1 = -1; n_fall = 0; prev_hs = 1'b1;
    for (int k = 0; k <= 1700; k++) begin
      if (k > 0) step();
      hp     = (k - 1) % 800;
      exp_hs = !((k >= 1) && (hp >= 656) && (hp <= 751));
      n_cmp++;
      if ({d1_h, d1_v, d1_hs} !== {10'(k % 800), 10'(k / 800), exp_hs}) begin
        n_bad++;
        $display("FAIL hsync_trace k=%0d: got h=%0d v=%0d hs=%b, expected %0d %0d %b",
                 k, d1_h, d1_v, d1_hs, k % 800, k / 800, exp_hs);
      end
      if (k < 800 && d1_hs == 1'b0) lows++;
      if (prev_hs && !d1_hs) begin
        if (n_fall == 0) begin fall0 = k; first_fall_h = int'(d1_h); end
        if (n_fall == 1) fall1 = k;
        n_fall++;
      end
      prev_hs = d1_hs;
    end
    n_cmp++;
    if (lows !== 96) begin
      n_bad++;
      $display("FAIL hsync_width: got %0d clocks low, expected 96", lows);
    end
    n_cmp++;
    if (first_fall_h !== 657) begin
      n_bad++;
      $display("FAIL hsync_first_low_h: got %0d, expected 657", first_fall_h);
    end
    n_cmp++;
    if (fall1 - fall0 !== 800) begin
      n_bad++;
      $display("FAIL hsync_period: got %0d, expected 800", fall1 - fall0);
    end
  endtask

  task automatic test_delay_0_3();
    int fall0_h, fall3_h, ls0_n, ls0_h, ls3_n, ls3_h;
    logic p0, p3;
    apply_reset();
    fall0_h = -1; fall3_h = -1; ls0_n = 0; ls0_h = -1; ls3_n = 0; ls3_h = -1; p0 = 1'b0; p3 = 1'b0;
    for (int k = 0; k < 800; k++) begin
      if (k > 0) step();
      if (k == 0) begin
        n_cmp++;
        if ({d0_act, d0_ls, d0_fs} !== 3'b111) begin
          n_bad++;
          $display("FAIL delay0_cycle0: got act=%b ls=%b fs=%b, expected 1 1 1", d0_act, d0_ls, d0_fs);
        end
      end
      if (k < 3) begin
        n_cmp++;
        if ({d3_act, d3_ls, d3_fs, d3_hs, d3_vs} !== 5'b00011) begin
          n_bad++;
          $display("FAIL delay3_inactive k=%0d: got act=%b ls=%b fs=%b hs=%b vs=%b, expected 0 0 0 1 1",
                   k, d3_act, d3_ls, d3_fs, d3_hs, d3_vs);
        end
      end
      if (k == 3) begin
        n_cmp++;
        if ({d3_act, d3_fs} !== 2'b11) begin
          n_bad++;
          $display("FAIL delay3_first_active: got act=%b fs=%b, expected 1 1", d3_act, d3_fs);
        end
      end
      if (p0 && !d0_act && fall0_h < 0) fall0_h = int'(d0_h);
      if (p3 && !d3_act && fall3_h < 0) fall3_h = int'(d3_h);
      if (d0_ls) begin ls0_n++; ls0_h = int'(d0_h); end
      if (d3_ls) begin ls3_n++; ls3_h = int'(d3_h); end
      p0 = d0_act;
      p3 = d3_act;
    end
    n_cmp++;
    if (fall0_h !== 640) begin
      n_bad++;
      $display("FAIL delay0_active_fall: got h=%0d, expected 640", fall0_h);
    end
    n_cmp++;
    if (fall3_h !== 643) begin
      n_bad++;
      $display("FAIL delay3_active_fall: got h=%0d, expected 643", fall3_h);
    end
    n_cmp++;
    if ({ls0_n, ls0_h} !== {32'sd1, 32'sd0}) begin
      n_bad++;
      $display("FAIL delay0_line_start: got count=%0d h=%0d, expected 1 0", ls0_n, ls0_h);
    end
    n_cmp++;
    if ({ls3_n, ls3_h} !== {32'sd1, 32'sd3}) begin
      n_bad++;
      $display("FAIL delay3_line_start: got count=%0d h=%0d, expected 1 3", ls3_n, ls3_h);
    end
  endtask

  task automatic test_vsync_frame();
    sm_exp_t e;
    int vs_hi, rise_h, rise_v, wraps, fs_n, fs0, fs1, fs2;
    logic pvs;
    logic [9:0] ph, pv;
    apply_reset();
    vs_hi = 0; rise_h = -1; rise_v = -1; wraps = 0; fs_n = 0; fs0 = -1; fs1 = -1; fs2 = -1;
    pvs = 1'b0; ph = '0; pv = '0;
    for (int k = 0; k <= 400; k++) begin
      if (k > 0) step();
      e = sm_model(k);
      n_cmp++;
      if ({sm_h, sm_v, sm_act, sm_hs, sm_vs, sm_ls, sm_fs} !== e) begin
        n_bad++;
        $display("FAIL small_raster k=%0d: got h=%0d v=%0d act=%b hs=%b vs=%b ls=%b fs=%b, expected %0d %0d %b %b %b %b %b",
                 k, sm_h, sm_v, sm_act, sm_hs, sm_vs, sm_ls, sm_fs, e.h, e.v, e.act, e.hs, e.vs, e.ls, e.fs);
      end
      if (k < 160 && sm_vs) vs_hi++;
      if (!pvs && sm_vs && rise_v < 0) begin rise_h = int'(sm_h); rise_v = int'(sm_v); end
      if (k > 0 && pv == 10'd9 && sm_v == 10'd0) begin
        wraps++;
        n_cmp++;
        if ({ph, sm_h} !== {10'd15, 10'd0}) begin
          n_bad++;
          $display("FAIL frame_wrap_h k=%0d: got h %0d->%0d, expected 15->0", k, ph, sm_h);
        end
      end
      if (sm_fs) begin
        if (fs_n == 0) fs0 = k;
        if (fs_n == 1) fs1 = k;
        if (fs_n == 2) fs2 = k;
        fs_n++;
      end
      pvs = sm_vs; ph = sm_h; pv = sm_v;
    end
    n_cmp++;
    if (vs_hi !== 32) begin
      n_bad++;
      $display("FAIL vsync_width: got %0d clocks, expected 32", vs_hi);
    end
    n_cmp++;
    if ({rise_v, rise_h} !== {32'sd7, 32'sd3}) begin
      n_bad++;
      $display("FAIL vsync_start: got v=%0d h=%0d, expected 7 3", rise_v, rise_h);
    end
    n_cmp++;
    if (wraps !== 2) begin
      n_bad++;
      $display("FAIL frame_wrap_count: got %0d, expected 2", wraps);
    end
    n_cmp++;
    if ({fs_n, fs0, fs1 - fs0, fs2 - fs1} !== {32'sd3, 32'sd3, 32'sd160, 32'sd160}) begin
      n_bad++;
      $display("FAIL frame_start_period: got n=%0d first=%0d periods=%0d,%0d, expected 3 3 160 160",
               fs_n, fs0, fs1 - fs0, fs2 - fs1);
    end
  endtask

  task automatic test_mid_reset();
    sm_exp_t e;
    apply_reset();
    for (int k = 1; k <= 53; k++) step();
    n_cmp++;
    if ({sm_h, sm_v, sm_act} !== {10'd5, 10'd3, 1'b1}) begin
      n_bad++;
      $display("FAIL mid_reset_pre: got h=%0d v=%0d act=%b, expected 5 3 1", sm_h, sm_v, sm_act);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({sm_h, sm_v, sm_act, sm_hs, sm_vs, sm_ls, sm_fs} !== 27'd0) begin
      n_bad++;
      $display("FAIL mid_reset_async_sm: got h=%0d v=%0d act=%b hs=%b vs=%b ls=%b fs=%b, expected all 0",
               sm_h, sm_v, sm_act, sm_hs, sm_vs, sm_ls, sm_fs);
    end
    n_cmp++;
    if ({d3_h, d3_v, d3_act, d3_hs, d3_vs, d3_ls, d3_fs} !== {10'd0, 10'd0, 5'b01100}) begin
      n_bad++;
      $display("FAIL mid_reset_async_d3: got h=%0d v=%0d act=%b hs=%b vs=%b ls=%b fs=%b, expected 0 0 0 1 1 0 0",
               d3_h, d3_v, d3_act, d3_hs, d3_vs, d3_ls, d3_fs);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) step();
      e = sm_model(k);
      n_cmp++;
      if ({sm_h, sm_v, sm_act, sm_hs, sm_vs, sm_ls, sm_fs} !== e) begin
        n_bad++;
        $display("FAIL mid_reset_restart k=%0d: got h=%0d v=%0d act=%b ls=%b fs=%b, expected %0d %0d %b %b %b",
                 k, sm_h, sm_v, sm_act, sm_ls, sm_fs, e.h, e.v, e.act, e.ls, e.fs);
      end
      n_cmp++;
      if ({d3_act, d3_fs} !== {(k >= 3), (k == 3)}) begin
        n_bad++;
        $display("FAIL mid_reset_restart_d3 k=%0d: got act=%b fs=%b, expected %b %b",
                 k, d3_act, d3_fs, (k >= 3), (k == 3));
      end
    end
  endtask

  task automatic test_frame_count();
    logic [7:0] exp_fc;
    apply_reset();
    for (int k = 1; k <= 40961; k++) begin
      step();
      if ((k % 160 == 0) || (k % 160 == 159)) begin
`ifdef VGA_FRAME_COUNTER_EN
        exp_fc = 8'((k / 160) % 256);
`else
        exp_fc = 8'd0;
`endif
        n_cmp++;
        if (sm_fc !== exp_fc) begin
          n_bad++;
          $display("FAIL frame_count k=%0d: got %0d, expected %0d", k, sm_fc, exp_fc);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_hsync();
    test_delay_0_3();
    test_vsync_frame();
    test_mid_reset();
    test_frame_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream stage of the background and sprite renderers. Generates the 640x480@60 raster position (h_count, v_count), sync pulses and blanking qualifier from the 25 MHz board pixel clock.
- Sync, active and strobe outputs pass through a configurable delay line, so they align with the BRAM read latency of downstream pixel stages.
- The final VGA output stage consumes the delayed sync signals. The background and sprite stages consume the undelayed counters.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_DELAY, 1, pipeline depth applied to hsync, vsync, display_active, line_start and frame_start; legal range 0..4
- SYNC_ACTIVE_LOW, 1, 1 means sync pulses drive 0 when asserted

Ports:
- clk  in  1  pixel clock, 25 MHz
- reset  in  1  asynchronous, active-high reset
- h_count  out  10  horizontal position, 0..H_TOTAL-1, undelayed
- v_count  out  10  vertical position, 0..V_TOTAL-1, undelayed
- display_active  out  1  high when h<H_VISIBLE and v<V_VISIBLE, delayed by SYNC_DELAY
- hsync  out  1  horizontal sync, polarity per SYNC_ACTIVE_LOW, delayed
- vsync  out  1  vertical sync, polarity per SYNC_ACTIVE_LOW, delayed
- line_start  out  1  one-clock pulse when h_count==0, delayed
- frame_start  out  1  one-clock pulse when h_count==0 and v_count==0, delayed
- frame_count  out  8  frame counter (optional feature; otherwise tied 0)

Behaviour:
- Totals: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
- Reset values:
  - h_count=0, v_count=0.
  - All delay-line stages cleared to the inactive state: display_active=0, line_start=0, frame_start=0, hsync/vsync at the deasserted level (1 when SYNC_ACTIVE_LOW=1).
  - frame_count=0.
- Counting:
  - h_count and v_count are registers. h_count increments every clk.
  - At h_count==H_TOTAL-1: h_count goes to 0 and v_count increments.
  - At h_count==H_TOTAL-1 and v_count==V_TOTAL-1: both go to 0 on the same edge.
  - No other states exist. Out-of-range values are unreachable, but any value >= H_TOTAL or V_TOTAL must still wrap to 0 on the next edge.
- Raw (undelayed) qualifiers are derived combinationally from the registered counters:
  - hs_raw asserted for h in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. 656..751.
  - vs_raw asserted for v in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. 490..491, for the full line width.
  - Active, line_start and frame_start are raw-derived using the conditions in Ports.
- Delay:
  - Each qualifier passes through SYNC_DELAY registers. With SYNC_DELAY=0, the outputs are combinational from the counters.
  - With SYNC_DELAY=N, the outputs reflect the counter value of N clocks earlier.
  - For the first N clocks after reset release, the outputs stay at their reset (inactive) values.
- Polarity inversion is applied after the delay line.
- Reset mid-frame: takes effect immediately (async). Counters and the delay line clear together, and the raster restarts at (0,0) on release.
- Consumer width: downstream stages taking a 9-bit v_count must gate with display_active. The block itself always drives the full 10 bits.

Optional Feature:
- Macro: VGA_FRAME_COUNTER_EN
- Defined:
  - frame_count increments by 1 on the edge where h_count wraps from H_TOTAL-1 and v_count from V_TOTAL-1.
  - Wraps 255->0; async reset to 0.
  - Used by animation and timer logic.
- Undefined: frame_count is a constant 0, and no counter register is synthesised.

Decomposition:
- Package vga_pkg holds the shared constants: default H_/V_ timing values, H_TOTAL, V_TOTAL, counter widths (10), TILE_SIZE (32).
- One sub-module: sync_delay_line.
  - Parameterised WIDTH and DEPTH shift register with async reset to a parameterised RESET_VALUE vector.
  - DEPTH=0 is a pass-through.
  - One instance carries {hs, vs, active, line_start, frame_start}.

Test Plan:
- Reset release, defaults: h_count=0 and v_count=0 on the first clock. With SYNC_DELAY=1, display_active=0 on cycle 0, then 1 from cycle 1. frame_start pulses exactly once on cycle 1.
- Hsync window: monitor line 0. hsync reads 0 for exactly 96 clocks, first at the clock where h_count==657 (delay 1). Period is 800 clocks.
- Vsync and frame wrap: run 420000 clocks.
  - vsync low for exactly 1600 clocks, starting on line 490.
  - v_count goes 524->0 simultaneously with h_count going 799->0.
  - frame_start period is 420000 clocks.
- SYNC_DELAY=0 and SYNC_DELAY=3 builds:
  - Falling edge of display_active at h_count==640 (delay 0) and at h_count==643 (delay 3).
  - line_start is high where h_count==0 (delay 0) and where h_count==3 (delay 3).
- Reset mid-frame: assert reset at (h=300, v=200) between clock edges. Outputs clear without waiting for a clock edge. After release the raster restarts at (0,0) with the full 3-clock inactive window (delay 3).
- VGA_FRAME_COUNTER_EN defined: run 256 frames and check frame_count goes 255->0; undefined: frame_count stays 0 throughout.
